lu_serial_driver: RTL and testbench
===================================

// Module: lu_serial_driver
// PURPOSE
//  Bit-serial initiator for the 1-bit logic unit (LU). Accepts a WIDTH-bit operand pair plus opcode.
//  Drives the LU's a/b/select/negate inputs one bit per clock, LSB first.
//  Samples the LU's combinational output each cycle and assembles a WIDTH-bit result.
//  The result is returned over a valid/ready handshake. The LU sits outside this block, between lu_* outputs and lu_out.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2); bit counter is $clog2(WIDTH) bits
// PORTS
//  clk         in   1      single clock, rising edge
//  reset       in   1      asynchronous, active-high reset
//  in_valid    in   1      command present
//  in_ready    out  1      block can accept a command (high only in IDLE)
//  op_a        in   WIDTH  operand A
//  op_b        in   WIDTH  operand B
//  op_sel      in   3      LU opcode: 000 NOT,001 AND,010 NAND,011 OR,100 NOR,101 XOR,110 XNOR,111 none
//  op_neg      in   1      invert A before the operation (LU negate)
//  lu_a        out  1      current A bit to LU
//  lu_b        out  1      current B bit to LU
//  lu_select   out  3      opcode to LU
//  lu_negate   out  1      negate to LU
//  lu_out      in   1      LU result bit (combinational from lu_* outputs)
//  out_valid   out  1      result available
//  out_ready   in   1      consumer takes result
//  result      out  WIDTH  assembled result
//  busy        out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, operand/opcode regs=0, result=0, lu_*=0, out_valid=0, busy=0, in_ready=1.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1. On an edge with in_valid=1, latch op_a, op_b, op_sel and op_neg; set idx=0; go to RUN.
//    Inputs are ignored when in_valid=0.
//  RUN: lu_a=a_reg[idx], lu_b=b_reg[idx], lu_select=sel_reg, lu_negate=neg_reg.
//    Each edge writes result[idx]<=lu_out.
//    If idx==WIDTH-1, go to DONE; otherwise idx<=idx+1. idx never wraps.
//    in_valid is ignored in RUN.
//  DONE: out_valid=1 and result is held stable. On an edge with out_ready=1, go to IDLE.
//    out_valid=0 and in_ready=1 take effect the following cycle.
//  Outside RUN, lu_a/lu_b/lu_negate=0 and lu_select=000.
//  result keeps its last value in IDLE and is overwritten bit by bit in RUN.
//  Latency: out_valid rises after the WIDTH-th edge following the accept edge.
//    Minimum command-to-command period is WIDTH+2 cycles.
//  op_sel=111 is accepted; the LU yields 0, so result is all zeros. No error is flagged.
//  The handshake is independent of in_valid/out_ready timing.
//    out_ready is ignored outside DONE.
//    out_ready held high gives a single-cycle out_valid pulse.
//  Asserting reset in RUN or DONE aborts immediately. All outputs return to reset values; the partial result is discarded.
// CONFIGURATION
//  LU_SEQ_PARITY_EN defined:
//    Adds output port result_parity (1 bit) = XOR of all result bits.
//    It is registered alongside each captured bit and valid whenever out_valid=1.
//    Reset value is 0.
//  Undefined: the port and its logic are absent; all other behaviour is identical.
// TESTING  (WIDTH=8, real LU connected to lu_* / lu_out)
//  AND: a=F0, b=CC, sel=001, neg=0 -> result=C0; out_valid rises 8 edges after accept; in_ready=0 meanwhile.
//  NOT+negate: a=5A, sel=000, neg=1 -> result=5A.
//  XOR: a=AA, b=FF, sel=101 -> result=55.
//  Backpressure: hold out_ready=0 for 5 cycles in DONE.
//    -> result, out_valid=1 and busy=1 are stable.
//    -> A new in_valid is not accepted until the cycle after the out_ready handshake.
//  Reset mid-op: pulse reset at idx=3 of a NOR command.
//    -> out_valid=0, result=00, lu_*=0, in_ready=1 immediately.
//  Unused opcode: sel=111, a=FF, b=FF -> result=00.
//    With LU_SEQ_PARITY_EN: NOR a=FE, b=00 -> result=01, result_parity=1.

Source files
------------

// File: rtl/lu_serial_driver.sv
// rtl/lu_serial_driver.sv - bit-serial initiator that drives a 1-bit logic unit and assembles its result
//
// Feeds the external LU one operand bit per clock, LSB first, and collects the
// LU's combinational output into a WIDTH-bit result. The result is returned over
// a valid/ready handshake.
//
// Optional feature macro: LU_SEQ_PARITY_EN
//   When defined, adds output result_parity = XOR of all result bits.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   command handshake (in_ready high only in IDLE)
//   op_a, op_b            WIDTH-bit operands
//   op_sel, op_neg        LU opcode and A-negate
//   lu_a, lu_b            current operand bits to the LU
//   lu_select, lu_negate  opcode and negate to the LU (zero outside RUN)
//   lu_out                LU result bit, combinational from lu_*
//   out_valid / out_ready result handshake
//   result                assembled result
//   busy                  high in RUN or DONE
//   result_parity         (LU_SEQ_PARITY_EN only) parity of result

module lu_serial_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       op_sel,
    input  logic             op_neg,
    output logic             lu_a,
    output logic             lu_b,
    output logic [2:0]       lu_select,
    output logic             lu_negate,
    input  logic             lu_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
`ifdef LU_SEQ_PARITY_EN
    ,
    output logic             result_parity
`endif
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_inc;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [2:0]       sel_reg;
    logic             neg_reg;
    logic [WIDTH-1:0] result_next;

    assign idx_inc = idx + 1'b1;

    // Result with the current LU bit merged in; parity is taken from this so it
    // stays in step with the captured bits.
    always_comb begin
        result_next      = result;
        result_next[idx] = lu_out;
    end

    // lu_* are registered: they are loaded one edge ahead with the bit that
    // idx will point at, so they equal a_reg[idx]/b_reg[idx] throughout RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sel_reg   <= 3'b000;
            neg_reg   <= 1'b0;
            result    <= '0;
            lu_a      <= 1'b0;
            lu_b      <= 1'b0;
            lu_select <= 3'b000;
            lu_negate <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
`ifdef LU_SEQ_PARITY_EN
            result_parity <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= op_a;
                        b_reg     <= op_b;
                        sel_reg   <= op_sel;
                        neg_reg   <= op_neg;
                        idx       <= '0;
                        lu_a      <= op_a[0];
                        lu_b      <= op_b[0];
                        lu_select <= op_sel;
                        lu_negate <= op_neg;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    result <= result_next;
`ifdef LU_SEQ_PARITY_EN
                    result_parity <= ^result_next;
`endif
                    if (idx == LAST_IDX) begin
                        lu_a      <= 1'b0;
                        lu_b      <= 1'b0;
                        lu_select <= 3'b000;
                        lu_negate <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx       <= idx_inc;
                        lu_a      <= a_reg[idx_inc];
                        lu_b      <= b_reg[idx_inc];
                        lu_select <= sel_reg;
                        lu_negate <= neg_reg;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lu_serial_driver.sv
// tb/tb_lu_serial_driver.sv - scoreboard testbench for lu_serial_driver with an attached LU model

module tb_lu_serial_driver;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]       op_sel;
    logic             op_neg;
    logic             lu_a;
    logic             lu_b;
    logic [2:0]       lu_select;
    logic             lu_negate;
    logic             lu_out;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;
`ifdef LU_SEQ_PARITY_EN
    logic             result_parity;
`endif

    int checks = 0;
    int errors = 0;
    bit rand_ready = 1'b0;
    logic [WIDTH-1:0] exp_q[$];

    lu_serial_driver #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
        .op_neg    (op_neg),
        .lu_a      (lu_a),
        .lu_b      (lu_b),
        .lu_select (lu_select),
        .lu_negate (lu_negate),
        .lu_out    (lu_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
`ifdef LU_SEQ_PARITY_EN
        ,
        .result_parity (result_parity)
`endif
    );

    always #5 clk = ~clk;

    // External 1-bit logic unit.
    logic lu_an;
    assign lu_an = lu_a ^ lu_negate;
    always_comb begin
        lu_out = 1'b0;
        case (lu_select)
            3'b000: lu_out = ~lu_an;
            3'b001: lu_out = lu_an & lu_b;
            3'b010: lu_out = ~(lu_an & lu_b);
            3'b011: lu_out = lu_an | lu_b;
            3'b100: lu_out = ~(lu_an | lu_b);
            3'b101: lu_out = lu_an ^ lu_b;
            3'b110: lu_out = ~(lu_an ^ lu_b);
            default: lu_out = 1'b0;
        endcase
    end

    // Whole-word reference of what the command should produce.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [2:0] s, input logic n);
        logic [WIDTH-1:0] x;
        x = n ? ~a : a;
        case (s)
            3'd0: return ~x;
            3'd1: return x & b;
            3'd2: return ~(x & b);
            3'd3: return x | b;
            3'd4: return ~(x | b);
            3'd5: return x ^ b;
            3'd6: return ~(x ^ b);
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Monitor: every result handshake is checked against the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            logic [WIDTH-1:0] e;
            if (exp_q.size() == 0) begin
                timeout("unexpected_result");
            end else begin
                e = exp_q.pop_front();
                chk("result", 32'(result), 32'(e));
                chk("busy_in_done", 32'(busy), 32'd1);
`ifdef LU_SEQ_PARITY_EN
                chk("result_parity", 32'(result_parity), 32'(^e));
`endif
            end
        end
    end

    // Random backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called #1 after a posedge; returns #1 after the accept edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] s, input logic n, input bit push);
        int guard = 0;
        bit acc = 1'b0;
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        op_sel = s;
        op_neg = n;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            guard++;
        end while (!acc && guard < 200);
        if (!acc) timeout("accept");
        else if (push) exp_q.push_back(model(a, b, s, n));
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int guard = 0;
        while (!out_valid && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        ok = out_valid;
        if (!ok) timeout("wait_out_valid");
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || !in_ready) && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 2000) timeout("drain");
    endtask

    initial begin
        bit ok;
        int n;
        reset = 1'b1;
        in_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        op_sel = '0;
        op_neg = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_lu", {26'd0, lu_a, lu_b, lu_select, lu_negate}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // AND with latency measurement.
        send(8'hF0, 8'hCC, 3'b001, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            chk("in_ready_while_run", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        chk("and_latency", 32'(n), 32'd8);
        wait_drain();

        send(8'h5A, 8'h00, 3'b000, 1'b1, 1'b1);  // NOT with negate -> 5A
        send(8'hAA, 8'hFF, 3'b101, 1'b0, 1'b1);  // XOR -> 55
        send(8'hFF, 8'hFF, 3'b111, 1'b0, 1'b1);  // unused opcode -> 00
        send(8'hFE, 8'h00, 3'b100, 1'b0, 1'b1);  // NOR -> 01, parity 1
        wait_drain();

        // Backpressure in DONE with a competing command held on in_valid.
        out_ready = 1'b0;
        send(8'hAA, 8'hFF, 3'b101, 1'b0, 1'b1);
        wait_valid(ok);
        in_valid = 1'b1;
        op_a = 8'h0F;
        op_b = 8'h33;
        op_sel = 3'b011;
        op_neg = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_result", 32'(result), 32'h55);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_in_ready", 32'(in_ready), 32'd1);
        chk("hs_out_valid", 32'(out_valid), 32'd0);
        exp_q.push_back(model(8'h0F, 8'h33, 3'b011, 1'b0));
        @(posedge clk);
        #1;
        chk("next_accepted", 32'(in_ready), 32'd0);
        chk("next_busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_drain();

        // Reset while RUN at idx=3 of a NOR command.
        send(8'h3C, 8'h81, 3'b100, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("run_lu_select", 32'(lu_select), 32'd4);
        chk("run_lu_a_bit3", 32'(lu_a), 32'd1);
        chk("run_lu_b_bit3", 32'(lu_b), 32'd0);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_lu", {26'd0, lu_a, lu_b, lu_select, lu_negate}, 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Randomized commands with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'b1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_drain();
        rand_ready = 1'b0;
        out_ready = 1'b1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
